// File: rtl/memory_responder_pkg.sv
// Shared types and constants for the memory responder: pipeline stage entry,
// latency bounds and the out-of-range address helper.
package memory_responder_pkg;

    localparam int MR_DATA_WIDTH  = 20;
    localparam int MR_LATENCY_MIN = 1;
    localparam int MR_LATENCY_MAX = 4;

    typedef struct packed {
        logic                     valid;
        logic                     wasWrite;
        logic                     rangeError;
        logic [MR_DATA_WIDTH-1:0] address;
        logic [MR_DATA_WIDTH-1:0] instruction;
        logic [MR_DATA_WIDTH-1:0] data;
    } stage_entry_t;

    function automatic logic addr_out_of_range(
        input logic [MR_DATA_WIDTH-1:0] addr,
        input int                       index_bits
    );
        logic hit;
        hit = 1'b0;
        for (int b = 0; b < MR_DATA_WIDTH; b++) begin
            if ((b >= index_bits) && addr[b]) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/memory_responder_ram.sv
// Single-port synchronous RAM: write-enable plus registered old-data read.
// Contents are never reset; only the read register is.
module memory_responder_ram
    import memory_responder_pkg::*;
#(
    parameter int DATA_WIDTH = MR_DATA_WIDTH,
    parameter int ADDR_BITS  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [ADDR_BITS-1:0]  addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_BITS];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read returns the contents before any write at the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_responder.sv
// Data-memory responder: fixed-latency in-order pipeline with valid/ready on
// both sides. Optional address range check: MEMORY_RESPONDER_RANGE_CHECK_EN.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int DATA_WIDTH   = MR_DATA_WIDTH,
    parameter int ADDR_BITS    = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWriteEnable,
    input  logic [DATA_WIDTH-1:0] reqAddress,
    input  logic [DATA_WIDTH-1:0] reqWriteData,
    input  logic [DATA_WIDTH-1:0] reqInstruction,
    output logic                  respValid,
    input  logic                  respReady,
    output logic [DATA_WIDTH-1:0] respData,
    output logic [DATA_WIDTH-1:0] respAddress,
    output logic [DATA_WIDTH-1:0] respInstruction,
    output logic                  respWasWrite,
    output logic                  rangeError
);

    localparam int LAT = (READ_LATENCY < MR_LATENCY_MIN) ? MR_LATENCY_MIN :
                         (READ_LATENCY > MR_LATENCY_MAX) ? MR_LATENCY_MAX : READ_LATENCY;

    stage_entry_t          stage_q [LAT];
    stage_entry_t          stage_d [LAT];
    stage_entry_t          new_entry_s;
    stage_entry_t          view_s;
    stage_entry_t          out_entry_s;
    logic                  advance_s;
    logic                  accept_s;
    logic                  range_s;
    logic                  ram_we_s;
    logic [DATA_WIDTH-1:0] ram_rdata_s;

`ifdef MEMORY_RESPONDER_RANGE_CHECK_EN
    assign range_s = addr_out_of_range(reqAddress, ADDR_BITS);
`else
    assign range_s = 1'b0;
`endif

    assign advance_s = !out_entry_s.valid || respReady;
    assign reqReady  = advance_s && !reset;
    assign accept_s  = reqValid && reqReady;
    assign ram_we_s  = accept_s && reqWriteEnable && !range_s;

    memory_responder_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .en_i    (accept_s),
        .we_i    (ram_we_s),
        .addr_i  (reqAddress[ADDR_BITS-1:0]),
        .wdata_i (reqWriteData),
        .rdata_o (ram_rdata_s)
    );

    always_comb begin
        new_entry_s = '0;
        if (accept_s) begin
            new_entry_s.valid       = 1'b1;
            new_entry_s.wasWrite    = reqWriteEnable;
            new_entry_s.rangeError  = range_s;
            new_entry_s.address     = reqAddress;
            new_entry_s.instruction = reqInstruction;
            new_entry_s.data        = reqWriteEnable ? reqWriteData : '0;
        end else begin
            new_entry_s.valid = 1'b0;
        end
    end

    // Stage 1 read data lives in the RAM read register; merge it in here.
    always_comb begin
        view_s = stage_q[0];
        if (!stage_q[0].valid) begin
            view_s.data = '0;
        end else if (stage_q[0].wasWrite) begin
            view_s.data = stage_q[0].data;
        end else if (stage_q[0].rangeError) begin
            view_s.data = '0;
        end else begin
            view_s.data = ram_rdata_s;
        end
    end

    always_comb begin
        for (int k = 0; k < LAT; k++) begin
            stage_d[k] = stage_q[k];
        end
        if (advance_s) begin
            stage_d[0] = new_entry_s;
            for (int k = 1; k < LAT; k++) begin
                stage_d[k] = (k == 1) ? view_s : stage_q[k-1];
            end
        end else begin
            for (int k = 0; k < LAT; k++) begin
                stage_d[k] = stage_q[k];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < LAT; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LAT; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign out_entry_s     = (LAT == 1) ? view_s : stage_q[LAT-1];
    assign respValid       = out_entry_s.valid;
    assign respData        = out_entry_s.data;
    assign respAddress     = out_entry_s.address;
    assign respInstruction = out_entry_s.instruction;
    assign respWasWrite    = out_entry_s.wasWrite;
    assign rangeError      = out_entry_s.rangeError;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder (READ_LATENCY=2): vector table plus
// hand-written back-pressure, reset and range sequences with a scoreboard.
module tb_memory_responder;

    localparam int DW = 20;

    logic          clock = 1'b0;
    logic          reset;
    logic          reqValid;
    logic          reqReady;
    logic          reqWriteEnable;
    logic [DW-1:0] reqAddress;
    logic [DW-1:0] reqWriteData;
    logic [DW-1:0] reqInstruction;
    logic          respValid;
    logic          respReady;
    logic [DW-1:0] respData;
    logic [DW-1:0] respAddress;
    logic [DW-1:0] respInstruction;
    logic          respWasWrite;
    logic          rangeError;

    memory_responder dut (
        .clock           (clock),
        .reset           (reset),
        .reqValid        (reqValid),
        .reqReady        (reqReady),
        .reqWriteEnable  (reqWriteEnable),
        .reqAddress      (reqAddress),
        .reqWriteData    (reqWriteData),
        .reqInstruction  (reqInstruction),
        .respValid       (respValid),
        .respReady       (respReady),
        .respData        (respData),
        .respAddress     (respAddress),
        .respInstruction (respInstruction),
        .respWasWrite    (respWasWrite),
        .rangeError      (rangeError)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          vld;
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] instr;
        logic          e_rv;
        logic [DW-1:0] e_data;
        logic [DW-1:0] e_addr;
        logic [DW-1:0] e_instr;
        logic          e_wr;
        logic          e_rerr;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [DW-1:0] addr;
        logic [DW-1:0] instr;
        logic          wr;
        logic          rerr;
    } exp_t;

    int            n_vec  = 0;
    int            n_miss = 0;
    exp_t          sb [$];
    logic [DW-1:0] mdl [256];
    logic          stall_prev = 1'b0;
    logic [DW-1:0] sv_data, sv_addr, sv_instr;
    vec_t          tbl [23];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic oor(input logic [DW-1:0] a);
        return |a[DW-1:8];
    endfunction

    function automatic vec_t mkv(input logic vld, input logic we, input logic [DW-1:0] addr,
                                 input logic [DW-1:0] wd, input logic [DW-1:0] instr,
                                 input logic e_rv, input logic [DW-1:0] e_data,
                                 input logic [DW-1:0] e_addr, input logic [DW-1:0] e_instr,
                                 input logic e_wr);
        vec_t v;
        v.vld = vld; v.we = we; v.addr = addr; v.wd = wd; v.instr = instr;
        v.e_rv = e_rv; v.e_data = e_data; v.e_addr = e_addr; v.e_instr = e_instr;
        v.e_wr = e_wr; v.e_rerr = 1'b0;
        return v;
    endfunction

    // One cycle of scoreboard-checked traffic; acc reports whether the request was taken.
    task automatic step(input logic vld, input logic we, input logic [DW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] instr,
                        input logic rrdy, output logic acc);
        exp_t e;
        logic rng;
        @(negedge clock);
        reqValid = vld; reqWriteEnable = we; reqAddress = addr;
        reqWriteData = wd; reqInstruction = instr; respReady = rrdy;
        #1;
        if (stall_prev) begin
            chk1("stall_valid", respValid, 1'b1);
            chk("stall_data", respData, sv_data);
            chk("stall_addr", respAddress, sv_addr);
            chk("stall_instr", respInstruction, sv_instr);
        end
        if (respValid && !respReady) chk1("bp_reqReady", reqReady, 1'b0);
        stall_prev = respValid && !respReady;
        sv_data = respData; sv_addr = respAddress; sv_instr = respInstruction;
        if (respValid && respReady) begin
            if (sb.size() == 0) begin
                chk1("spurious_resp", respValid, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("sb_data", respData, e.data);
                chk("sb_addr", respAddress, e.addr);
                chk("sb_instr", respInstruction, e.instr);
                chk1("sb_wr", respWasWrite, e.wr);
                chk1("sb_rerr", rangeError, e.rerr);
            end
        end
        acc = vld && reqReady;
        if (acc) begin
            rng = 1'b0;
`ifdef MEMORY_RESPONDER_RANGE_CHECK_EN
            rng = oor(addr);
`endif
            e.addr = addr; e.instr = instr; e.wr = we; e.rerr = rng;
            if (rng) begin
                e.data = we ? wd : '0;
            end else if (we) begin
                e.data = wd;
                mdl[addr[7:0]] = wd;
            end else begin
                e.data = mdl[addr[7:0]];
            end
            sb.push_back(e);
        end
    endtask

    initial begin
        logic acc;
        int   issued;

        tbl[0]  = mkv(1, 1, 20'h00005, 20'hABCDE, 20'h00100, 0, 0, 0, 0, 0);
        tbl[1]  = mkv(1, 0, 20'h00005, 20'h0,     20'h00101, 0, 0, 0, 0, 0);
        tbl[2]  = mkv(1, 1, 20'h00007, 20'h11111, 20'h00102, 1, 20'hABCDE, 20'h00005, 20'h00100, 1);
        tbl[3]  = mkv(1, 0, 20'h00007, 20'h0,     20'h00103, 1, 20'hABCDE, 20'h00005, 20'h00101, 0);
        tbl[4]  = mkv(1, 1, 20'h00007, 20'h22222, 20'h00104, 1, 20'h11111, 20'h00007, 20'h00102, 1);
        tbl[5]  = mkv(1, 0, 20'h00007, 20'h0,     20'h00105, 1, 20'h11111, 20'h00007, 20'h00103, 0);
        tbl[6]  = mkv(0, 0, 20'h0, 20'h0, 20'h0,             1, 20'h22222, 20'h00007, 20'h00104, 1);
        tbl[7]  = mkv(0, 0, 20'h0, 20'h0, 20'h0,             1, 20'h22222, 20'h00007, 20'h00105, 0);
        tbl[8]  = mkv(0, 0, 20'h0, 20'h0, 20'h0,             0, 0, 0, 0, 0);
        tbl[9]  = mkv(1, 0, 20'h00005, 20'h0, 20'h00001,     0, 0, 0, 0, 0);
        tbl[10] = mkv(0, 0, 20'h0, 20'h0, 20'h0,             0, 0, 0, 0, 0);
        tbl[11] = mkv(1, 0, 20'h00007, 20'h0, 20'h00002,     1, 20'hABCDE, 20'h00005, 20'h00001, 0);
        tbl[12] = mkv(0, 0, 20'h0, 20'h0, 20'h0,             0, 0, 0, 0, 0);
        tbl[13] = mkv(0, 0, 20'h0, 20'h0, 20'h0,             1, 20'h22222, 20'h00007, 20'h00002, 0);
        tbl[14] = mkv(1, 1, 20'h00009, 20'h00042, 20'h00003, 0, 0, 0, 0, 0);
        tbl[15] = mkv(1, 0, 20'h00009, 20'h0, 20'h00004,     0, 0, 0, 0, 0);
        tbl[16] = mkv(0, 0, 20'h0, 20'h0, 20'h0,             1, 20'h00042, 20'h00009, 20'h00003, 1);
        tbl[17] = mkv(0, 0, 20'h0, 20'h0, 20'h0,             1, 20'h00042, 20'h00009, 20'h00004, 0);
        tbl[18] = mkv(0, 0, 20'h0, 20'h0, 20'h0,             0, 0, 0, 0, 0);
        tbl[19] = mkv(1, 0, 20'h00105, 20'h0, 20'h00006,     0, 0, 0, 0, 0);
        tbl[20] = mkv(0, 0, 20'h0, 20'h0, 20'h0,             0, 0, 0, 0, 0);
`ifdef MEMORY_RESPONDER_RANGE_CHECK_EN
        tbl[21] = mkv(0, 0, 20'h0, 20'h0, 20'h0,             1, 20'h00000, 20'h00105, 20'h00006, 0);
        tbl[21].e_rerr = 1'b1;
`else
        tbl[21] = mkv(0, 0, 20'h0, 20'h0, 20'h0,             1, 20'hABCDE, 20'h00105, 20'h00006, 0);
`endif
        tbl[22] = mkv(0, 0, 20'h0, 20'h0, 20'h0,             0, 0, 0, 0, 0);

        reset = 1'b1; reqValid = 1'b0; reqWriteEnable = 1'b0; reqAddress = '0;
        reqWriteData = '0; reqInstruction = '0; respReady = 1'b1;
        #1;
        chk1("reset_reqReady", reqReady, 1'b0);
        chk1("reset_respValid", respValid, 1'b0);
        chk("reset_respData", respData, '0);
        chk("reset_respAddress", respAddress, '0);
        chk("reset_respInstr", respInstruction, '0);
        chk1("reset_wasWrite", respWasWrite, 1'b0);
        chk1("reset_rangeError", rangeError, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            @(negedge clock);
            reqValid = tbl[i].vld; reqWriteEnable = tbl[i].we; reqAddress = tbl[i].addr;
            reqWriteData = tbl[i].wd; reqInstruction = tbl[i].instr; respReady = 1'b1;
            #1;
            chk1($sformatf("vec%0d_reqReady", i), reqReady, 1'b1);
            chk1($sformatf("vec%0d_respValid", i), respValid, tbl[i].e_rv);
            if (tbl[i].e_rv) begin
                chk($sformatf("vec%0d_data", i), respData, tbl[i].e_data);
                chk($sformatf("vec%0d_addr", i), respAddress, tbl[i].e_addr);
                chk($sformatf("vec%0d_instr", i), respInstruction, tbl[i].e_instr);
                chk1($sformatf("vec%0d_wr", i), respWasWrite, tbl[i].e_wr);
                chk1($sformatf("vec%0d_rerr", i), rangeError, tbl[i].e_rerr);
            end
        end

        // Back-pressure: preload 0..5, stream six reads, stall the consumer 4 cycles.
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b1, DW'(k), 20'h10000 + DW'(k * 32'h111), 20'h00300 + DW'(k), 1'b1, acc);
        end
        issued = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            step(issued < 6, 1'b0, DW'(issued), 20'h0, 20'h00200 + DW'(issued),
                 !(cyc >= 2 && cyc < 6), acc);
            if (acc) issued++;
        end
        chk("bp_issued", DW'(issued), 20'd6);
        repeat (4) step(1'b0, 1'b0, 20'h0, 20'h0, 20'h0, 1'b1, acc);
        chk("bp_drained", DW'(sb.size()), 20'd0);

        // Reset mid-stream discards in-flight reads.
        step(1'b1, 1'b0, 20'h00000, 20'h0, 20'h00401, 1'b1, acc);
        step(1'b1, 1'b0, 20'h00001, 20'h0, 20'h00402, 1'b1, acc);
        step(1'b1, 1'b0, 20'h00002, 20'h0, 20'h00403, 1'b1, acc);
        @(negedge clock);
        reqValid = 1'b0; respReady = 1'b0;
        #1;
        chk1("prereset_valid", respValid, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk1("midreset_respValid", respValid, 1'b0);
        chk1("midreset_reqReady", reqReady, 1'b0);
        chk("midreset_respData", respData, '0);
        @(negedge clock);
        chk1("midreset_reqReady2", reqReady, 1'b0);
        reset = 1'b0;
        sb.delete();
        stall_prev = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, 20'h0, 20'h0, 20'h0, 1'b1, acc);
            chk1($sformatf("postreset_idle%0d", k), respValid, 1'b0);
        end

        // Out-of-range write/read: flagged when the check is built in, aliased otherwise.
        step(1'b1, 1'b1, 20'h00005, 20'h0AAAA, 20'h00501, 1'b1, acc);
        step(1'b1, 1'b1, 20'h00105, 20'h12345, 20'h00502, 1'b1, acc);
        step(1'b1, 1'b0, 20'h00005, 20'h0,     20'h00503, 1'b1, acc);
        step(1'b1, 1'b0, 20'h00105, 20'h0,     20'h00504, 1'b1, acc);
        repeat (4) step(1'b0, 1'b0, 20'h0, 20'h0, 20'h0, 1'b1, acc);
        chk("final_drained", DW'(sb.size()), 20'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
